uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-byte front end for the boot loader path. It synchronizes and oversamples the `uart_rx` pin and deserializes 8N1 frames. Received bytes are buffered in a small FIFO and handed to the UART loader through a valid/ready handshake, so memory write stalls in the loader never lose bytes. It sits between the top-level `uart_rx` pin and `uart_loader`, and reports framing and overflow errors for the status display.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per bit (100 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 16: byte FIFO entries. Must be a power of 2, ≥ 2.
- `clk`  in  1  100 MHz system clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  raw serial line, asynchronous, idle high.
- `byte_data`  out  8  FIFO head byte. Valid only while `byte_valid`=1.
- `byte_valid`  out  1  FIFO non-empty.
- `byte_ready`  in  1  consumer accepts head. Pop occurs when `byte_valid & byte_ready`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overflow_err`  out  1  sticky: a byte was dropped because the FIFO was full.
- `err_clr`  in  1  single-cycle pulse that clears both sticky flags.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized `rxs`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxs`=0, load bit counter = CLKS_PER_BIT/2−1 and go to START.
  - START: when the counter reaches 0, sample `rxs`.
    - If 1: false start, go to IDLE.
    - If 0: load counter = CLKS_PER_BIT−1, set bit_idx = 0, go to DATA.
  - DATA: each time the counter reaches 0, shift `rxs` into bit 7 of the shift register (shift right, LSB first), reload the counter, and increment bit_idx. After bit_idx 7 is sampled, go to STOP.
  - STOP: when the counter reaches 0, sample `rxs`.
    - If 1: push the shift register into the FIFO and go to IDLE.
    - If 0: set `frame_err`, discard the byte, and go to BREAK.
  - BREAK: stay until `rxs`=1, then go to IDLE. This prevents a held-low line from being re-detected as a new start bit.
- FIFO behaviour:
  - Show-ahead: `byte_data` = mem[rd_ptr].
  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs of the pointers differ and the low bits are equal. empty = pointers equal.
- Push while full with no pop in the same cycle: the byte is dropped, `overflow_err` is set, and FIFO contents are unchanged.
- Push while full with a pop in the same cycle: the push is accepted and the count is unchanged.
- Push and pop in the same cycle on an empty FIFO: no pop occurs (valid is 0). The push lands and the count becomes 1.
- Flag updates:
  - If `err_clr` coincides with a new error event, the flag ends up set (set wins).
  - A new error event while the flag is already set leaves it set.
- The receiver never stalls. Backpressure only fills the FIFO.

## Timing
- Reset values:
  - FSM = IDLE; both synchronizer flops = 1.
  - `byte_valid`=0, `fifo_count`=0, `frame_err`=0, `overflow_err`=0.
  - `byte_data` = don't-care while invalid.
- Pin-to-detection latency is 2 cycles (synchronizer). Let t0 be the cycle in which IDLE sees `rxs`=0. Sample points:
  - start bit: t0 + CLKS_PER_BIT/2
  - data bit i: t0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT
  - stop bit: t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- Delivery: `byte_valid` and the new `fifo_count` appear on the cycle after the stop sample.
- Back-to-back frames: the FSM is in IDLE from the cycle after the stop sample, i.e. half a bit before the nominal stop end. This tolerates up to ~4% baud mismatch.
- Pop: `fifo_count` decrements and `byte_data` advances on the cycle after the `valid & ready` edge.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial byte and all FIFO contents are lost.

## Structure
- `UART_CLKS_PER_BIT` belongs in `definitions.vh` so that `uart_loader` and the top level share it.
- Sub-module `byte_fifo`: a parameterized DEPTH×8 show-ahead FIFO providing full, empty and count. The receiver FSM stays in `uart_receiver`.

## Test plan
- CLKS_PER_BIT=16; send 0xA5 at the nominal rate → `byte_valid`=1 with `byte_data`=0xA5 one cycle after the stop sample; `fifo_count`=1; no error flags.
- Drive a 3-cycle low glitch on `rx` → FSM returns to IDLE from START; no push; `frame_err`=0.
- Send 0x3C with the stop bit held low for 2 bit times, then a normal 0x42 → `frame_err`=1; the FIFO holds only 0x42; pulsing `err_clr` clears `frame_err`.
- With `byte_ready`=0, send 17 bytes 0x00..0x10 into a 16-deep FIFO → `fifo_count`=16; `overflow_err`=1; popped sequence is 0x00..0x0F (0x10 dropped).
- FIFO full and `byte_ready`=1 held from the cycle of the next stop sample → the push is accepted, `fifo_count` stays 16, and `overflow_err` stays 0.
- Assert `rst_n` low in the middle of DATA with 3 bytes queued → all outputs return to reset values; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver FSM encoding and default bit timing.
package uart_receiver_pkg;

  // 100 MHz / 115200 baud; shared with uart_loader and top level.
  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_FIFO_DEPTH   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Byte handshake + status bundle between receiver and loader.
// master: receiver side; slave: consumer/status side.
interface uart_receiver_if #(
  parameter int FIFO_DEPTH = 16
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic [CW-1:0] fifo_count;
  logic          frame_err;
  logic          overflow_err;
  logic          err_clr;

  modport master (
    output byte_data,
    output byte_valid,
    output fifo_count,
    output frame_err,
    output overflow_err,
    input  byte_ready,
    input  err_clr
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    input  fifo_count,
    input  frame_err,
    input  overflow_err,
    output byte_ready,
    output err_clr
  );

endinterface

// File: rtl/byte_fifo.sv
// DEPTH x 8 show-ahead FIFO with full/empty/count.
// Ports: push_i/data_i write, pop_i read, data_o = head.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the slot being written, so a
  // full FIFO still accepts a simultaneous push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: contents are only
  // visible while the pointers say non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: sync, oversample, deserialize, FIFO.
// Ports: clk, rst_n, rx pin, bus (byte handshake + errors).
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = UART_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  uart_receiver_if.master bus
);

  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNTW-1:0] HALF =
    CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] FULL =
    CNTW'(CLKS_PER_BIT - 1);

  logic [1:0]      sync_q, sync_d;
  logic            rxs;
  rx_state_e       state_q;
  logic [CNTW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            cnt_zero;
  logic            stop_smp;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            frame_set;
  logic            ovf_set;
  logic            frame_q, frame_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   count;

  assign sync_d = {sync_q[0], rx};
  assign rxs    = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            cnt_q   <= HALF;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rxs) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q     <= FULL;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q   <= {rxs, shift_q[7:1]};
            cnt_q     <= FULL;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rxs) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_BREAK;
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it is not
          // mistaken for a fresh start bit.
          if (rxs) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cnt_zero  = (cnt_q == '0);
  assign stop_smp  = (state_q == S_STOP) & cnt_zero;
  assign push      = stop_smp & rxs;
  assign frame_set = stop_smp & ~rxs;
  assign pop       = bus.byte_ready & ~empty;
  assign ovf_set   = push & full & ~pop;

  // Set wins over a coincident clear.
  always_comb begin
    frame_d = frame_set | (frame_q & ~bus.err_clr);
    ovf_d   = ovf_set | (ovf_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      ovf_q   <= ovf_d;
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (shift_q),
    .pop_i  (pop),
    .data_o (bus.byte_data),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  assign bus.byte_valid   = ~empty;
  assign bus.fifo_count   = count;
  assign bus.frame_err    = frame_q;
  assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clks/bit.
// Frames are bit-banged on rx; outputs checked #1 after edges.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_receiver_if #(.FIFO_DEPTH(DEP)) bus ();

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit + 8 data bits; ends 144 cycles in.
  task automatic send_data(input logic [7:0] b);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input int stop_low);
    send_data(b);
    if (stop_low > 0) begin
      rx = 1'b0;
      tick(stop_low * CPB);
    end
    rx = 1'b1;
    tick(CPB);
  endtask

  initial begin
    rst_n          = 1'b0;
    rx             = 1'b1;
    bus.byte_ready = 1'b0;
    bus.err_clr    = 1'b0;
    tick(3);
    check("rst_valid", 32'(bus.byte_valid), 0);
    check("rst_count", 32'(bus.fifo_count), 0);
    check("rst_ferr", 32'(bus.frame_err), 0);
    check("rst_oerr", 32'(bus.overflow_err), 0);
    rst_n = 1'b1;
    tick(5);

    // Nominal 0xA5; stop sample falls at edge 154.
    send_data(8'hA5);
    rx = 1'b1;
    tick(10);
    check("a5_early", 32'(bus.byte_valid), 0);
    tick(1);
    check("a5_valid", 32'(bus.byte_valid), 1);
    check("a5_data", 32'(bus.byte_data), 32'hA5);
    check("a5_count", 32'(bus.fifo_count), 1);
    check("a5_ferr", 32'(bus.frame_err), 0);
    check("a5_oerr", 32'(bus.overflow_err), 0);
    tick(5);
    bus.byte_ready = 1'b1;
    tick(1);
    bus.byte_ready = 1'b0;
    check("a5_popcnt", 32'(bus.fifo_count), 0);
    check("a5_popval", 32'(bus.byte_valid), 0);

    // 3-cycle glitch: false start.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    check("gl_count", 32'(bus.fifo_count), 0);
    check("gl_ferr", 32'(bus.frame_err), 0);

    // Framing error then a clean byte.
    send_frame(8'h3C, 2);
    check("fe_set", 32'(bus.frame_err), 1);
    check("fe_empty", 32'(bus.fifo_count), 0);
    tick(CPB);
    send_frame(8'h42, 0);
    check("fe_count", 32'(bus.fifo_count), 1);
    check("fe_data", 32'(bus.byte_data), 32'h42);
    check("fe_hold", 32'(bus.frame_err), 1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("fe_clr", 32'(bus.frame_err), 0);
    bus.byte_ready = 1'b1;
    tick(1);
    bus.byte_ready = 1'b0;

    // Overflow: 17 bytes into 16 slots.
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 0);
    end
    check("of_cnt16", 32'(bus.fifo_count), 16);
    check("of_nooerr", 32'(bus.overflow_err), 0);
    send_frame(8'h10, 0);
    check("of_count", 32'(bus.fifo_count), 16);
    check("of_oerr", 32'(bus.overflow_err), 1);
    bus.byte_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("of_pop", 32'(bus.byte_data), 32'(i));
      tick(1);
    end
    bus.byte_ready = 1'b0;
    check("of_drain", 32'(bus.byte_valid), 0);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("of_clr", 32'(bus.overflow_err), 0);

    // Full FIFO with pop coinciding with push.
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(8'h20 + i), 0);
    end
    check("fp_cnt16", 32'(bus.fifo_count), 16);
    send_data(8'h55);
    rx = 1'b1;
    tick(10);
    bus.byte_ready = 1'b1;
    tick(1);
    bus.byte_ready = 1'b0;
    check("fp_count", 32'(bus.fifo_count), 16);
    check("fp_oerr", 32'(bus.overflow_err), 0);
    check("fp_head", 32'(bus.byte_data), 32'h21);
    tick(5);
    bus.byte_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fp_pop", 32'(bus.byte_data),
            (i < 15) ? 32'(8'h21 + i) : 32'h55);
      tick(1);
    end
    bus.byte_ready = 1'b0;
    check("fp_drain", 32'(bus.fifo_count), 0);

    // Reset mid-frame with bytes queued.
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    send_frame(8'h33, 0);
    send_frame(8'h77, 1);
    check("rs_pre_cnt", 32'(bus.fifo_count), 3);
    check("rs_pre_fe", 32'(bus.frame_err), 1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    rx = 1'b0;
    tick(2 * CPB);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check("rs_count", 32'(bus.fifo_count), 0);
    check("rs_valid", 32'(bus.byte_valid), 0);
    check("rs_ferr", 32'(bus.frame_err), 0);
    check("rs_oerr", 32'(bus.overflow_err), 0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    send_frame(8'h81, 0);
    check("rs_valid2", 32'(bus.byte_valid), 1);
    check("rs_data", 32'(bus.byte_data), 32'h81);
    check("rs_count2", 32'(bus.fifo_count), 1);
    check("rs_ferr2", 32'(bus.frame_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
